// File: rtl/pattern_pwm_multi_pkg.sv
// Shared constants, FSM encoding and helpers for pattern_pwm_multi.
// Defining PATTERN_PWM_PHASE_EN widens cfg_addr and adds the per-channel start phase delay.
package pattern_pwm_multi_pkg;

  localparam int unsigned DefNumCh    = 8;
  localparam int unsigned DefPatWidth = 16;
  localparam int unsigned DefDutyW    = 8;
  localparam int unsigned DefDessW    = 16;
  localparam int unsigned DefPnumW    = 8;

  localparam int unsigned CfgDataW = 16;
`ifdef PATTERN_PWM_PHASE_EN
  localparam int unsigned CfgAddrW = 3;
`else
  localparam int unsigned CfgAddrW = 2;
`endif

  localparam int unsigned CfgDuty  = 0;
  localparam int unsigned CfgDess  = 1;
  localparam int unsigned CfgPnum  = 2;
  localparam int unsigned CfgPat   = 3;
  localparam int unsigned CfgPhase = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDone  = 2'd2,
    StPhase = 2'd3
  } ch_state_e;

  function automatic int unsigned ch_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_pwm_multi_if.sv
// Config strobes, start/stop pulses and per-channel status between the packet decoder and
// pattern_pwm_multi.
interface pattern_pwm_multi_if import pattern_pwm_multi_pkg::*; #(
  parameter int unsigned NUM_CH = DefNumCh,
  parameter int unsigned CH_W   = ch_width(NUM_CH)
) ();

  logic [NUM_CH-1:0]   start;
  logic [NUM_CH-1:0]   stop;
  logic                cfg_wr;
  logic [CH_W-1:0]     cfg_ch;
  logic [CfgAddrW-1:0] cfg_addr;
  logic [CfgDataW-1:0] cfg_wdata;
  logic [NUM_CH-1:0]   pwm_out;
  logic [NUM_CH-1:0]   busy;
  logic [NUM_CH-1:0]   valid;

  modport master (
    output start, stop, cfg_wr, cfg_ch, cfg_addr, cfg_wdata,
    input  pwm_out, busy, valid
  );

  modport slave (
    input  start, stop, cfg_wr, cfg_ch, cfg_addr, cfg_wdata,
    output pwm_out, busy, valid
  );

endinterface

// File: rtl/pattern_pwm_multi_ch.sv
// One pattern PWM channel: shadow/active config, slot/bit/pattern counters and run FSM.
// With PATTERN_PWM_PHASE_EN a programmable idle-but-busy delay precedes the first slot.
module pattern_pwm_multi_ch import pattern_pwm_multi_pkg::*; #(
  parameter int unsigned PAT_W  = DefPatWidth,
  parameter int unsigned DUTY_W = DefDutyW,
  parameter int unsigned DESS_W = DefDessW,
  parameter int unsigned PNUM_W = DefPnumW
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_wr_en,
  input  logic [CfgAddrW-1:0] i_cfg_addr,
  input  logic [CfgDataW-1:0] i_cfg_wdata,
  output logic                o_pwm,
  output logic                o_busy,
  output logic                o_valid
);

  localparam int unsigned SlotW = DESS_W + 1;
  localparam int unsigned IdxW  = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  logic [DUTY_W-1:0] r_sh_duty, w_sh_duty_d, r_duty;
  logic [DESS_W-1:0] r_sh_dess, w_sh_dess_d, r_dess;
  logic [PNUM_W-1:0] r_sh_pnum, w_sh_pnum_d, r_pnum;
  logic [PAT_W-1:0]  r_sh_pat, w_sh_pat_d, r_pat;
`ifdef PATTERN_PWM_PHASE_EN
  logic [DESS_W-1:0] r_sh_phase, w_sh_phase_d;
`endif

  ch_state_e         r_state, w_state_d;
  logic [SlotW-1:0]  r_cyc, w_cyc_d, w_cyc_inc, w_len;
  logic [IdxW-1:0]   r_slot, w_slot_d, w_slot_inc;
  logic [PNUM_W-1:0] r_pcnt, w_pcnt_d;
  logic              r_pwm, w_pwm_d;
  logic              w_load, w_last_cyc, w_last_slot, w_last_pat, w_first_bit;

  // A write landing in the same cycle as a start/boundary is forwarded into the active copy.
  always_comb begin
    w_sh_duty_d  = r_sh_duty;
    w_sh_dess_d  = r_sh_dess;
    w_sh_pnum_d  = r_sh_pnum;
    w_sh_pat_d   = r_sh_pat;
`ifdef PATTERN_PWM_PHASE_EN
    w_sh_phase_d = r_sh_phase;
`endif
    if (i_wr_en) begin
      case (i_cfg_addr)
        CfgAddrW'(CfgDuty):  w_sh_duty_d  = i_cfg_wdata[DUTY_W-1:0];
        CfgAddrW'(CfgDess):  w_sh_dess_d  = i_cfg_wdata[DESS_W-1:0];
        CfgAddrW'(CfgPnum):  w_sh_pnum_d  = i_cfg_wdata[PNUM_W-1:0];
        CfgAddrW'(CfgPat):   w_sh_pat_d   = i_cfg_wdata[PAT_W-1:0];
`ifdef PATTERN_PWM_PHASE_EN
        CfgAddrW'(CfgPhase): w_sh_phase_d = i_cfg_wdata[DESS_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  assign w_len       = SlotW'(r_duty) + SlotW'(r_dess);
  assign w_cyc_inc   = r_cyc + SlotW'(1);
  assign w_last_cyc  = (w_len == '0) || (w_cyc_inc == w_len);
  assign w_slot_inc  = r_slot + IdxW'(1);
  assign w_last_slot = (r_slot == IdxW'(PAT_W - 1));
  assign w_last_pat  = (r_pnum != '0) && ((r_pcnt + PNUM_W'(1)) == r_pnum);
  assign w_first_bit = w_sh_pat_d[0] && (w_sh_duty_d != '0);

  always_comb begin
    w_state_d = r_state;
    w_cyc_d   = r_cyc;
    w_slot_d  = r_slot;
    w_pcnt_d  = r_pcnt;
    w_pwm_d   = 1'b0;
    w_load    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start && !i_stop) begin
          w_load   = 1'b1;
          w_cyc_d  = '0;
          w_slot_d = '0;
          w_pcnt_d = '0;
`ifdef PATTERN_PWM_PHASE_EN
          if (w_sh_phase_d != '0) begin
            w_state_d = StPhase;
            w_cyc_d   = SlotW'(w_sh_phase_d) - SlotW'(1);
          end else begin
            w_state_d = StRun;
            w_pwm_d   = w_first_bit;
          end
`else
          w_state_d = StRun;
          w_pwm_d   = w_first_bit;
`endif
        end
      end
      StPhase: begin
        if (i_stop) begin
          w_state_d = StIdle;
        end else if (r_cyc == '0) begin
          w_state_d = StRun;
          w_pwm_d   = r_pat[0] && (r_duty != '0);
        end else begin
          w_cyc_d = r_cyc - SlotW'(1);
        end
      end
      StRun: begin
        if (i_stop) begin
          w_state_d = StIdle;
        end else if (!w_last_cyc) begin
          w_cyc_d = w_cyc_inc;
          w_pwm_d = r_pat[r_slot] && (w_cyc_inc < SlotW'(r_duty));
        end else if (!w_last_slot) begin
          w_cyc_d  = '0;
          w_slot_d = w_slot_inc;
          w_pwm_d  = r_pat[w_slot_inc] && (r_duty != '0);
        end else if (w_last_pat) begin
          w_state_d = StDone;
        end else begin
          // Pattern boundary: reload active config, infinite mode leaves the counter alone.
          w_load   = 1'b1;
          w_cyc_d  = '0;
          w_slot_d = '0;
          if (r_pnum != '0) w_pcnt_d = r_pcnt + PNUM_W'(1);
          w_pwm_d  = w_first_bit;
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sh_duty  <= '0;
      r_sh_dess  <= '0;
      r_sh_pnum  <= '0;
      r_sh_pat   <= '0;
`ifdef PATTERN_PWM_PHASE_EN
      r_sh_phase <= '0;
`endif
      r_duty     <= '0;
      r_dess     <= '0;
      r_pnum     <= '0;
      r_pat      <= '0;
      r_state    <= StIdle;
      r_cyc      <= '0;
      r_slot     <= '0;
      r_pcnt     <= '0;
      r_pwm      <= 1'b0;
    end else begin
      r_sh_duty  <= w_sh_duty_d;
      r_sh_dess  <= w_sh_dess_d;
      r_sh_pnum  <= w_sh_pnum_d;
      r_sh_pat   <= w_sh_pat_d;
`ifdef PATTERN_PWM_PHASE_EN
      r_sh_phase <= w_sh_phase_d;
`endif
      if (w_load) begin
        r_duty <= w_sh_duty_d;
        r_dess <= w_sh_dess_d;
        r_pnum <= w_sh_pnum_d;
        r_pat  <= w_sh_pat_d;
      end
      r_state <= w_state_d;
      r_cyc   <= w_cyc_d;
      r_slot  <= w_slot_d;
      r_pcnt  <= w_pcnt_d;
      r_pwm   <= w_pwm_d;
    end
  end

  assign o_pwm   = r_pwm;
  assign o_busy  = (r_state == StRun) || (r_state == StPhase);
  assign o_valid = (r_state == StDone);

endmodule

// File: rtl/pattern_pwm_multi.sv
// NUM_CH-channel double-buffered pattern PWM engine; decodes cfg_ch into per-channel writes.
// Build option: PATTERN_PWM_PHASE_EN adds cfg_addr 4 (per-channel start phase delay).
module pattern_pwm_multi import pattern_pwm_multi_pkg::*; #(
  parameter int unsigned NUM_CH     = DefNumCh,
  parameter int unsigned _PAT_WIDTH = DefPatWidth,
  parameter int unsigned DUTY_W     = DefDutyW,
  parameter int unsigned DESS_W     = DefDessW,
  parameter int unsigned PNUM_W     = DefPnumW
) (
  input logic                i_sys_clk,
  input logic                i_sys_rst_n,
  pattern_pwm_multi_if.slave io_bus
);

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] w_wr_en;
  logic [NUM_CH-1:0] w_pwm;
  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_valid;

  // Out-of-range cfg_ch values match no channel and are dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr_en[g] = io_bus.cfg_wr && (io_bus.cfg_ch == CH_W'(g));

    pattern_pwm_multi_ch #(
      .PAT_W  (_PAT_WIDTH),
      .DUTY_W (DUTY_W),
      .DESS_W (DESS_W),
      .PNUM_W (PNUM_W)
    ) u_ch (
      .i_clk       (i_sys_clk),
      .i_rst_n     (i_sys_rst_n),
      .i_start     (io_bus.start[g]),
      .i_stop      (io_bus.stop[g]),
      .i_wr_en     (w_wr_en[g]),
      .i_cfg_addr  (io_bus.cfg_addr),
      .i_cfg_wdata (io_bus.cfg_wdata),
      .o_pwm       (w_pwm[g]),
      .o_busy      (w_busy[g]),
      .o_valid     (w_valid[g])
    );
  end

  assign io_bus.pwm_out = w_pwm;
  assign io_bus.busy    = w_busy;
  assign io_bus.valid   = w_valid;

endmodule

// File: tb/tb_pattern_pwm_multi.sv
// Scoreboard bench for pattern_pwm_multi: table-driven runs plus hand-written corner sequences.
module tb_pattern_pwm_multi;
  import pattern_pwm_multi_pkg::*;

  localparam int unsigned NC = 6;
  localparam int unsigned CW = ch_width(NC);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pattern_pwm_multi_if #(.NUM_CH(NC), .CH_W(CW)) io ();

  pattern_pwm_multi #(.NUM_CH(NC)) dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .io_bus      (io)
  );

  typedef struct {
    int          ch;
    int          duty;
    int          dess;
    logic [15:0] pat;
    int          pnum;
    string       tag;
  } vec_t;

  typedef struct {
    logic [NC-1:0] mask;
    logic [NC-1:0] pwm;
    logic [NC-1:0] busy;
    logic [NC-1:0] valid;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference waveform: first pattern uses (d0,s0), later ones (d1,s1); k=1 is the first cycle
  // after the start edge; shift models a start phase delay.
  function automatic logic [2:0] model(int d0, int s0, int d1, int s1, logic [15:0] pat,
                                       int pnum, int shift, int k);
    int kk, l0, l1, p0, total, t, len, d, slot, off;
    kk = k - shift;
    if (kk < 1) return 3'b010;
    l0 = (d0 + s0 == 0) ? 1 : d0 + s0;
    l1 = (d1 + s1 == 0) ? 1 : d1 + s1;
    p0 = 16 * l0;
    if (pnum != 0) begin
      total = p0 + (pnum - 1) * 16 * l1;
      if (kk > total) return {1'b0, 1'b0, kk == total + 1};
    end
    t = kk - 1;
    if (t < p0) begin
      len = l0; d = d0;
    end else begin
      t = (t - p0) % (16 * l1); len = l1; d = d1;
    end
    slot = t / len;
    off  = t % len;
    return {pat[slot] && (off < d), 1'b1, 1'b0};
  endfunction

  function automatic exp_t mk(int ch, logic [2:0] b, string tag);
    exp_t e;
    e.mask = '0; e.pwm = '0; e.busy = '0; e.valid = '0;
    e.mask[ch] = 1'b1; e.pwm[ch] = b[2]; e.busy[ch] = b[1]; e.valid[ch] = b[0];
    e.tag = tag;
    return e;
  endfunction

  task automatic clear_pulses();
    io.start  = '0;
    io.stop   = '0;
    io.cfg_wr = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    clear_pulses();
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty t=%0t got nothing to compare, want an entry", $time);
    end else begin
      e = sb.pop_front();
      if ((((io.pwm_out ^ e.pwm) | (io.busy ^ e.busy) | (io.valid ^ e.valid)) & e.mask) !== '0)
      begin
        failures++;
        $display("FAIL %s t=%0t got pwm=%b busy=%b valid=%b want pwm=%b busy=%b valid=%b mask=%b",
                 e.tag, $time, io.pwm_out, io.busy, io.valid, e.pwm, e.busy, e.valid, e.mask);
      end
    end
    clear_pulses();
  endtask

  task automatic check_vec(string name, logic [NC-1:0] act, logic [NC-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic cfg_write(int ch, int addr, int data);
    io.cfg_ch    = CW'(ch);
    io.cfg_addr  = CfgAddrW'(addr);
    io.cfg_wdata = 16'(data);
    io.cfg_wr    = 1'b1;
    tick();
  endtask

  task automatic cfg_vec(vec_t v);
    cfg_write(v.ch, CfgDuty, v.duty);
    cfg_write(v.ch, CfgDess, v.dess);
    cfg_write(v.ch, CfgPnum, v.pnum);
    cfg_write(v.ch, CfgPat, int'(v.pat));
  endtask

  task automatic push_idle(int ch, int n, string tag);
    for (int i = 0; i < n; i++) sb.push_back(mk(ch, 3'b000, tag));
  endtask

  task automatic play_vec(vec_t v);
    int l, total;
    l = (v.duty + v.dess == 0) ? 1 : v.duty + v.dess;
    total = 16 * l * v.pnum;
    io.start[v.ch] = 1'b1;
    for (int k = 1; k <= total + 3; k++)
      sb.push_back(mk(v.ch, model(v.duty, v.dess, v.duty, v.dess, v.pat, v.pnum, 0, k), v.tag));
    for (int k = 1; k <= total + 3; k++) step();
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{ch: 0, duty: 2, dess: 3, pat: 16'h0005, pnum: 1, tag: "v0_basic"};
    vecs[1] = '{ch: 3, duty: 0, dess: 0, pat: 16'hFFFF, pnum: 2, tag: "v1_zero_len"};
    vecs[2] = '{ch: 4, duty: 3, dess: 0, pat: 16'hA5A5, pnum: 1, tag: "v2_full_duty"};
    vecs[3] = '{ch: 5, duty: 1, dess: 2, pat: 16'h8001, pnum: 2, tag: "v3_edge_bits"};
    vecs[4] = '{ch: 2, duty: 5, dess: 1, pat: 16'h00F0, pnum: 1, tag: "v4_mid_bits"};

    io.cfg_ch = '0; io.cfg_addr = '0; io.cfg_wdata = '0;
    clear_pulses();
    rst_n = 1'b0;
    repeat (3) tick();
    check_vec("reset_pwm", io.pwm_out, '0);
    check_vec("reset_busy", io.busy, '0);
    check_vec("reset_valid", io.valid, '0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      cfg_vec(vecs[i]);
      play_vec(vecs[i]);
    end

    // Infinite mode on ch1, stopped after 100 cycles.
    cfg_write(1, CfgDuty, 1);
    cfg_write(1, CfgDess, 1);
    cfg_write(1, CfgPnum, 0);
    cfg_write(1, CfgPat, 16'hFFFF);
    io.start[1] = 1'b1;
    for (int k = 1; k <= 100; k++)
      sb.push_back(mk(1, model(1, 1, 1, 1, 16'hFFFF, 0, 0, k), "infinite"));
    for (int k = 1; k <= 100; k++) step();
    io.stop[1] = 1'b1;
    push_idle(1, 5, "infinite_stop");
    for (int k = 0; k < 5; k++) step();

    // Duty rewritten mid-pattern on ch2: takes effect only at the next pattern boundary.
    cfg_write(2, CfgDuty, 4);
    cfg_write(2, CfgDess, 4);
    cfg_write(2, CfgPnum, 2);
    cfg_write(2, CfgPat, 16'hFFFF);
    io.start[2] = 1'b1;
    for (int k = 1; k <= 211; k++)
      sb.push_back(mk(2, model(4, 4, 1, 4, 16'hFFFF, 2, 0, k), "shadow_switch"));
    for (int k = 1; k <= 19; k++) step();
    io.cfg_ch = CW'(2); io.cfg_addr = CfgAddrW'(CfgDuty); io.cfg_wdata = 16'd1;
    io.cfg_wr = 1'b1;
    for (int k = 20; k <= 211; k++) step();

    // Out-of-range channel writes must leave ch0 (and every other channel) untouched.
    for (int c = NC; c < (1 << CW); c++)
      for (int a = 0; a < 4; a++) cfg_write(c, a, 16'hFFFF);
    play_vec(vecs[0]);

    // start and stop together: stop wins.
    io.start[3] = 1'b1;
    io.stop[3]  = 1'b1;
    push_idle(3, 4, "start_stop");
    for (int k = 0; k < 4; k++) step();

    // Reset in the middle of a run.
    io.start[4] = 1'b1;
    for (int k = 1; k <= 10; k++)
      sb.push_back(mk(4, model(3, 0, 3, 0, 16'hA5A5, 1, 0, k), "pre_reset"));
    for (int k = 1; k <= 10; k++) step();
    rst_n = 1'b0;
    tick();
    check_vec("midrst_pwm", io.pwm_out, '0);
    check_vec("midrst_busy", io.busy, '0);
    check_vec("midrst_valid", io.valid, '0);
    rst_n = 1'b1;
    push_idle(4, 5, "post_reset");
    for (int k = 0; k < 5; k++) step();

    // Shadow regs cleared by reset: ch0 now runs forever with a silent output.
    io.start[0] = 1'b1;
    for (int k = 1; k <= 20; k++)
      sb.push_back(mk(0, model(0, 0, 0, 0, 16'h0000, 0, 0, k), "zero_cfg"));
    for (int k = 1; k <= 20; k++) step();
    io.stop[0] = 1'b1;
    push_idle(0, 3, "zero_cfg_stop");
    for (int k = 0; k < 3; k++) step();

`ifdef PATTERN_PWM_PHASE_EN
    for (int c = 0; c < 2; c++) begin
      cfg_write(c, CfgDuty, 2);
      cfg_write(c, CfgDess, 1);
      cfg_write(c, CfgPnum, 1);
      cfg_write(c, CfgPat, 16'h1234);
    end
    cfg_write(0, CfgPhase, 0);
    cfg_write(1, CfgPhase, 10);
    io.start[1:0] = 2'b11;
    for (int k = 1; k <= 61; k++) begin
      exp_t e0, e1;
      e0 = mk(0, model(2, 1, 2, 1, 16'h1234, 1, 0, k), "phase");
      e1 = mk(1, model(2, 1, 2, 1, 16'h1234, 1, 10, k), "phase");
      e0.mask  |= e1.mask;
      e0.pwm   |= e1.pwm;
      e0.busy  |= e1.busy;
      e0.valid |= e1.valid;
      sb.push_back(e0);
    end
    for (int k = 1; k <= 61; k++) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
